// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by an N_TICK-times oversampling tick.
// Samples the start bit at its centre, then every data bit and the stop bit one bit period apart.
module uart_rx #(
    parameter int N_DATA = 8,
    parameter int N_TICK = 16,
    parameter int N_SYNC = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_data,
    input  logic              i_valid,
    output logic [N_DATA-1:0] o_data,
    output logic              o_rx_done,
    output logic              o_frame_err
);

    localparam int TW = (N_TICK > 1) ? $clog2(N_TICK) : 1;
    localparam int BW = (N_DATA > 1) ? $clog2(N_DATA) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(N_TICK / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(N_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [N_SYNC-1:0] sync_q;
    logic              rx_s;
    logic [TW-1:0]     tick_cnt, tick_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [N_DATA-1:0] shreg, shreg_nxt;
    logic [N_DATA-1:0] data_nxt;
    logic              done_nxt, err_nxt;

    // Reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) sync_q <= '1;
        else          sync_q <= {sync_q[N_SYNC-2:0], i_data};
    end

    assign rx_s = sync_q[N_SYNC-1];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_nxt;
            bit_cnt     <= bit_nxt;
            shreg       <= shreg_nxt;
            o_data      <= data_nxt;
            o_rx_done   <= done_nxt;
            o_frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        data_nxt  = o_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                end
            end
            START: begin
                if (i_valid) begin
                    if (tick_cnt == TICK_HALF) begin
                        // A line that is high again at mid start bit was only a glitch.
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_valid) begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg_nxt = {rx_s, shreg[N_DATA-1:1]};
                        tick_nxt  = '0;
                        if (bit_cnt == BIT_LAST) state_nxt = STOP;
                        else                     bit_nxt   = bit_cnt + BW'(1);
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (i_valid) begin
                    if (tick_cnt == TICK_LAST) begin
                        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                        state_nxt = IDLE;
                        tick_nxt  = '0;
                        if (rx_s) begin
                            data_nxt = shreg;
                            done_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are serialised from bytes, expected strobes queued per frame,
// and a negedge monitor checks every strobe, its data and its latency from the start edge.
module tb_uart_rx;

    localparam int N_DATA = 8;
    localparam int N_TICK = 16;
    localparam int N_SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tick;
    logic [7:0]  dout;
    logic        done;
    logic        ferr;

    uart_rx #(.N_DATA(N_DATA), .N_TICK(N_TICK), .N_SYNC(N_SYNC)) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_data     (rx),
        .i_valid    (tick),
        .o_data     (dout),
        .o_rx_done  (done),
        .o_frame_err(ferr)
    );

    always #5 clk = ~clk;

    int div = 4;
    int tcnt = 0;
    int cyc = 0;
    int bitclk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tcnt <= (tcnt >= div - 1) ? 0 : tcnt + 1;
    end
    assign tick = (tcnt == div - 1);

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         start;
        int         bclk;
        bit         chk_lat;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    exp_t mon_e;
    int   lat, lat_lo, lat_hi;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done && ferr) begin
                checks++; errors++;
                $display("FAIL both_strobes: rx_done and frame_err high together at cycle %0d", cyc);
            end else if (done || ferr) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b data=%h, none expected",
                             done, ferr, dout);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.err != ferr || dout != mon_e.data) begin
                        errors++;
                        $display("FAIL strobe: got frame_err=%0b data=%h, expected frame_err=%0b data=%h",
                                 ferr, dout, mon_e.err, mon_e.data);
                    end
                    if (mon_e.chk_lat) begin
                        // Mid stop bit is 9.5 bit times after the edge, then sync, FSM entry and tick phase.
                        lat    = cyc - mon_e.start;
                        lat_lo = (19 * mon_e.bclk) / 2 + N_SYNC + 1 - div;
                        lat_hi = (19 * mon_e.bclk) / 2 + N_SYNC + 2;
                        checks++;
                        if (lat < lat_lo || lat > lat_hi) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, lat_lo, lat_hi);
                        end
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad, input int bc, input bit chk);
        exp_t e;
        e.err     = bad;
        e.data    = bad ? last_good : b;
        e.start   = cyc;
        e.bclk    = bc;
        e.chk_lat = chk;
        q.push_back(e);
        if (!bad) last_good = b;
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        // A bad stop bit is released after 3/4 bit so the post-error restart sees a clean glitch.
        if (bad) begin
            hold(1'b0, (3 * bc) / 4);
            hold(1'b1, bc - (3 * bc) / 4);
        end else begin
            hold(1'b1, bc);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        hold(1'b1, 2 * bitclk);
        while (q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes missing", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        bitclk = N_TICK * div;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_state", {dout, done, ferr}, 10'h000);
        rst_n = 1'b1;
        hold(1'b1, 2 * bitclk);

        send(8'h55, 1'b0, bitclk, 1'b1);
        drain("single_byte");

        send(8'hA3, 1'b0, bitclk, 1'b1);
        send(8'h0F, 1'b0, bitclk, 1'b1);
        drain("back_to_back");

        hold(1'b0, 5 * div);
        hold(1'b1, 2 * bitclk);
        send(8'h7E, 1'b0, bitclk, 1'b1);
        drain("glitch_then_byte");

        send(8'h11, 1'b0, bitclk, 1'b1);
        send(8'h3C, 1'b1, bitclk, 1'b1);
        drain("framing_error");
        check_val("data_held_after_err", {dout, done, ferr}, {8'h11, 2'b00});

        // 0xFF interrupted by reset in the middle of data bit 3.
        hold(1'b0, bitclk);
        hold(1'b1, 3 * bitclk + bitclk / 2);
        #3 rst_n = 1'b0;
        #1 check_val("reset_mid_frame", {dout, done, ferr}, 10'h000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_good = 8'h00;
        hold(1'b1, bitclk);
        send(8'h81, 1'b0, bitclk, 1'b1);
        drain("after_reset");

        send(8'hC6, 1'b0, (bitclk * 103) / 100, 1'b0);
        hold(1'b1, bitclk);
        send(8'hC6, 1'b0, (bitclk * 97) / 100, 1'b0);
        drain("baud_skew");

        for (int i = 0; i < 20; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send(b, bad, bitclk, 1'b1);
            hold(1'b1, bad ? bitclk : $urandom_range(0, 2) * (bitclk / 2));
        end
        drain("random_div4");

        div    = 1;
        bitclk = N_TICK * div;
        hold(1'b1, 4 * bitclk);
        for (int i = 0; i < 20; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send(b, bad, bitclk, 1'b1);
            hold(1'b1, bad ? bitclk : $urandom_range(0, 2) * (bitclk / 2));
        end
        drain("random_tick_every_cycle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the BIP debug link: deserializes 8N1 frames arriving on the board `RsRx` pin and presents each received byte with a one-cycle strobe. It is the receive-side counterpart of `uart_tx` and shares its oversampling tick from `baudrate_generator`. It sits upstream of the BIP/UART interface and supplies host commands to it, such as run, step, and request dump.

## Interface
Parameters:
- `N_DATA`, 8: data bits per frame, sent LSB first.
- `N_TICK`, 16: oversampling ticks per bit. Must be even and ≥ 4.
- `N_SYNC`, 2: flops in the `i_data` synchronizer chain, ≥ 2.

Ports:
- `i_clock`, input, 1: system clock. All state is in this single clock domain.
- `i_reset`, input, 1: reset, asynchronous, active-low.
- `i_data`, input, 1: serial line, asynchronous to the clock. Idle level is 1.
- `i_valid`, input, 1: oversampling tick from `baudrate_generator`, at `N_TICK` × baud. A single-cycle pulse.
- `o_data`, output, `N_DATA`: last correctly framed byte. Held until the next good frame.
- `o_rx_done`, output, 1: one-cycle pulse when `o_data` is updated.
- `o_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled as 0.

## Operation
- **Synchronizer.** `i_data` passes through `N_SYNC` flops to give `rx_s`. All flops reset to 1, the idle line level.
- **Counters.**
  - `tick_cnt` has width clog2(`N_TICK`). It advances only on cycles where `i_valid` = 1.
  - `bit_cnt` has width clog2(`N_DATA`).
  - A shift register `shreg` has width `N_DATA`.
- **FSM states:** IDLE, START, DATA, STOP. The reset state is IDLE.
  - **IDLE.** When `rx_s` = 0, go to START and clear `tick_cnt`. `i_valid` is not required for this transition.
  - **START.** On each tick:
    - If `tick_cnt` = `N_TICK`/2−1 and `rx_s` = 0, go to DATA and clear `tick_cnt` and `bit_cnt`.
    - If `tick_cnt` = `N_TICK`/2−1 and `rx_s` = 1, treat it as a glitch and return to IDLE with no output.
    - Otherwise increment `tick_cnt`.
  - **DATA.** On each tick:
    - If `tick_cnt` = `N_TICK`−1, shift right with `shreg` ← {`rx_s`, `shreg[N_DATA-1:1]`} and clear `tick_cnt`.
    - After that shift, if `bit_cnt` = `N_DATA`−1 go to STOP; otherwise increment `bit_cnt`.
    - Otherwise increment `tick_cnt`.
  - **STOP.** On the tick where `tick_cnt` = `N_TICK`−1, which is mid stop bit, return to IDLE:
    - If `rx_s` = 1, load `o_data` ← `shreg` and pulse `o_rx_done`.
    - If `rx_s` = 0, pulse `o_frame_err` and leave `o_data` unchanged.
- **Break condition.** A line held at 0 after a framing error raises `o_frame_err` once. The FSM then re-enters START from IDLE and raises further errors or glitches only as frames complete. It never hangs.
- `o_rx_done` and `o_frame_err` are never asserted in the same cycle.
- **Reset values.**
  - Outputs: `o_data` = 0, `o_rx_done` = 0, `o_frame_err` = 0.
  - Internal state: FSM = IDLE, counters = 0, `shreg` = 0.
- **Reset mid-frame.** The partial frame is discarded with no pulse. Reception resumes at the next falling edge seen after reset is released.

## Timing
- Input latency: `N_SYNC` clocks from a pin edge to `rx_s`.
- Sample points:
  - Start bit is checked `N_TICK`/2 ticks after the falling edge is detected.
  - Each data bit and the stop bit are sampled `N_TICK` ticks after the previous sample, at bit centre.
- `o_rx_done` and `o_frame_err` are registered. Each goes high the clock after the sampling tick and is high for exactly 1 cycle.
- `o_data` changes in the same cycle that `o_rx_done` goes high.
- Frame to strobe: about (1 + `N_DATA` + 0.5) bit times after the start edge, plus `N_SYNC` + 1 clocks.
- Returning to IDLE at mid stop bit allows back-to-back frames with no idle gap. Transmitter/receiver baud mismatch up to ±3 % is tolerated.
- `i_valid` may pulse on any cycle, including every cycle. Correctness depends only on the tick count.

## Test plan
- **Single byte.** Send 0x55 (8N1), with `i_valid` every 4 clocks and `N_TICK` = 16. Expect `o_data` = 0x55 and exactly one `o_rx_done` pulse.
- **Back-to-back frames.** Send 0xA3 then 0x0F with no idle between the stop bit and the next start bit. Expect two `o_rx_done` pulses, with `o_data` = 0xA3 then 0x0F. Expect no `o_frame_err`.
- **Start glitch.** Drive the line low for 5 ticks, then high. Expect no `o_rx_done` and no `o_frame_err`. Then send 0x7E and expect it received correctly.
- **Framing error.** First receive 0x11. Then send 0x3C with the stop bit forced to 0. Expect one `o_frame_err` pulse, no `o_rx_done`, and `o_data` still 0x11.
- **Reset mid-frame.** Assert `i_reset` low during data bit 3 of 0xFF. Expect all outputs 0 immediately, with no clock edge needed. Release reset, send 0x81, and expect `o_data` = 0x81 with one `o_rx_done`.
- **Baud skew.** Send 0xC6 with the transmitter bit period 3 % long, then again 3 % short. Expect `o_data` = 0xC6 in both cases.
